// File: rtl/page_key_ctrl.sv
// Page-button front end: per-key sync, debounce, press/auto-repeat events,
// and a timed four-phase req/ack handshake toward the page display.
module page_key_ctrl #(
  parameter int CNT_W         = 25,
  parameter int DEB_CYCLES    = 1000000,
  parameter int HOLD_CYCLES   = 25000000,
  parameter int REPEAT_CYCLES = 5000000,
  parameter int ACK_TO        = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_up,
  input  logic       key_dn,
  input  logic       fdu,
  input  logic       fdd,
  output logic       fsu,
  output logic       fsd,
  output logic       busy,
  output logic       err,
  output logic [1:0] key_lvl
);

  // state | meaning
  // IDLE  | no request outstanding, scanning pend_u then pend_d
  // REQ_U | fsu high, waiting for fdu
  // REL_U | fsu dropped, waiting for fdu to fall
  // REQ_D | fsd high, waiting for fdd
  // REL_D | fsd dropped, waiting for fdd to fall
  typedef enum logic [2:0] {IDLE, REQ_U, REL_U, REQ_D, REL_D} state_t;

  localparam int TO_W = $clog2(ACK_TO);
  localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_RELOAD = CNT_W'(HOLD_CYCLES - REPEAT_CYCLES);
  localparam logic [TO_W-1:0]  TO_LAST     = TO_W'(ACK_TO - 1);

  // index 1 = up, index 0 = dn, matching key_lvl
  logic [1:0]       sync1, sync2;
  logic [CNT_W-1:0] deb_cnt  [2];
  logic [CNT_W-1:0] hold_cnt [2];
  logic [1:0]       s, deb_tc, rise, fall, rep, ev;
  logic             pend_u, pend_d, launch_u, launch_d, to_tc;
  logic [TO_W-1:0]  to_cnt;
  state_t           state;

  always_comb begin
    s      = ~sync2;
    deb_tc = '0;
    rise   = '0;
    fall   = '0;
    rep    = '0;
    for (int i = 0; i < 2; i++) begin
      deb_tc[i] = (s[i] != key_lvl[i]) && (deb_cnt[i] == DEB_LAST);
      rise[i]   = deb_tc[i] & s[i];
      fall[i]   = deb_tc[i] & ~s[i];
      // a repeat landing on the release edge is suppressed
      rep[i]    = key_lvl[i] && !fall[i] && (hold_cnt[i] == HOLD_LAST);
    end
    ev       = rise | rep;
    launch_u = (state == IDLE) && pend_u;
    launch_d = (state == IDLE) && !pend_u && pend_d;
    to_tc    = (to_cnt == TO_LAST);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1       <= '1;
      sync2       <= '1;
      key_lvl     <= '0;
      deb_cnt[0]  <= '0;
      deb_cnt[1]  <= '0;
      hold_cnt[0] <= '0;
      hold_cnt[1] <= '0;
    end else begin
      sync1 <= {key_up, key_dn};
      sync2 <= sync1;
      for (int i = 0; i < 2; i++) begin
        if (s[i] == key_lvl[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_tc[i]) begin
          deb_cnt[i] <= '0;
          key_lvl[i] <= s[i];
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 1'b1;
        end

        if (!key_lvl[i] || fall[i])
          hold_cnt[i] <= '0;
        else if (rep[i])
          hold_cnt[i] <= HOLD_RELOAD;
        else
          hold_cnt[i] <= hold_cnt[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      to_cnt <= '0;
      pend_u <= 1'b0;
      pend_d <= 1'b0;
      fsu    <= 1'b0;
      fsd    <= 1'b0;
      busy   <= 1'b0;
      err    <= 1'b0;
    end else begin
      // a new event on the launch edge is kept rather than lost
      pend_u <= ev[1] | (pend_u & ~launch_u);
      pend_d <= ev[0] | (pend_d & ~launch_d);
      err    <= 1'b0;
      case (state)
        IDLE: begin
          to_cnt <= '0;
          if (pend_u) begin
            state <= REQ_U;
            fsu   <= 1'b1;
            busy  <= 1'b1;
          end else if (pend_d) begin
            state <= REQ_D;
            fsd   <= 1'b1;
            busy  <= 1'b1;
          end
        end
        REQ_U: begin
          if (fdu) begin
            state  <= REL_U;
            fsu    <= 1'b0;
            to_cnt <= '0;
          end else if (to_tc) begin
            state  <= IDLE;
            fsu    <= 1'b0;
            busy   <= 1'b0;
            err    <= 1'b1;
            to_cnt <= '0;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        REL_U: begin
          if (!fdu || to_tc) begin
            state  <= IDLE;
            busy   <= 1'b0;
            err    <= fdu;
            to_cnt <= '0;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        REQ_D: begin
          if (fdd) begin
            state  <= REL_D;
            fsd    <= 1'b0;
            to_cnt <= '0;
          end else if (to_tc) begin
            state  <= IDLE;
            fsd    <= 1'b0;
            busy   <= 1'b0;
            err    <= 1'b1;
            to_cnt <= '0;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        REL_D: begin
          if (!fdd || to_tc) begin
            state  <= IDLE;
            busy   <= 1'b0;
            err    <= fdd;
            to_cnt <= '0;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          fsu    <= 1'b0;
          fsd    <= 1'b0;
          busy   <= 1'b0;
          to_cnt <= '0;
        end
      endcase
    end
  end

endmodule
